// File: rtl/ej2_pkg.sv
// Shared types and constants for the ej2 control-word sequencer.
// Optional macro SEQ_STEP_EN (used by the interface and top) adds a step-gated RUN.
package ej2_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} seq_state_t;

    localparam int CTRL_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;

    // One-hot transfer enables for the T3..T0 datapath lines
    localparam logic [3:0] T0_EN = 4'b0001;
    localparam logic [3:0] T1_EN = 4'b0010;
    localparam logic [3:0] T2_EN = 4'b0100;
    localparam logic [3:0] T3_EN = 4'b1000;

endpackage

// File: rtl/ej2_ctrl_seq_if.sv
// Program/run/control bundle between the sequencer (master) and its user (slave).
// Defining SEQ_STEP_EN adds the step input.
interface ej2_ctrl_seq_if #(
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 3
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [CTRL_W-1:0] prog_data;
    logic [ADDR_W:0]   seq_len;
    logic              start;
`ifdef SEQ_STEP_EN
    logic              step;
`endif
    logic [CTRL_W-1:0] control;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] seq_idx;
    logic              wr_err;

`ifdef SEQ_STEP_EN
    modport master (input prog_we, prog_addr, prog_data, seq_len, start, step,
                    output control, busy, done, seq_idx, wr_err);
    modport slave  (output prog_we, prog_addr, prog_data, seq_len, start, step,
                    input control, busy, done, seq_idx, wr_err);
`else
    modport master (input prog_we, prog_addr, prog_data, seq_len, start,
                    output control, busy, done, seq_idx, wr_err);
    modport slave  (output prog_we, prog_addr, prog_data, seq_len, start,
                    input control, busy, done, seq_idx, wr_err);
`endif

endinterface

// File: rtl/ej2_prog_mem.sv
// DEPTH x CTRL_W program register file: synchronous write and clear, asynchronous read.
module ej2_prog_mem #(
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CTRL_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CTRL_W-1:0] rdata
);

    logic [CTRL_W-1:0] mem_q [DEPTH];
    logic [CTRL_W-1:0] mem_d [DEPTH];

    // Clear wins over write; out-of-range addresses are dropped silently
    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        end else if (we && (int'(waddr) < DEPTH)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/ej2_ctrl_seq.sv
// Replays a loaded program of control words onto T3..T0, one per clock, then pulses done.
// Defining SEQ_STEP_EN makes RUN advance only on cycles with step=1.
module ej2_ctrl_seq
    import ej2_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    ej2_ctrl_seq_if.master bus
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              wr_err_q, wr_err_d;
    logic              mem_we;
    logic              advance;
    logic [CTRL_W-1:0] mem_rdata;

`ifdef SEQ_STEP_EN
    assign advance = bus.step;
`else
    assign advance = 1'b1;
`endif

    assign mem_we = bus.prog_we && (state_q != RUN);

    ej2_prog_mem #(
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .clr   (!rst_n),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        wr_err_d = bus.prog_we && (state_q == RUN);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = (bus.seq_len > DEPTH_L) ? DEPTH_L : bus.seq_len;
                    idx_d   = '0;
                    state_d = (len_d == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (advance) begin
                    if ({1'b0, idx_q} == (len_q - ONE_L)) state_d = FIN;
                    else                                  idx_d   = idx_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally
    assign bus.control = (state_q == RUN) ? mem_rdata : '0;
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == FIN);
    assign bus.seq_idx = idx_q;
    assign bus.wr_err  = wr_err_q;

endmodule

// File: tb/tb_ej2_ctrl_seq.sv
// Randomized bench for ej2_ctrl_seq against a queue-based playback model.
// Build with SEQ_STEP_EN defined to also exercise the step-gated run.
module tb_ej2_ctrl_seq;
    import ej2_pkg::*;

    logic clk;
    logic rst_n;
    logic stepDrive;

    int checkCount = 0;
    int errorCount = 0;

    logic [3:0] modelMem [8];
    logic [3:0] runQ [$];
    bit         inFin;
    int         modelIdx;
    bit         expWrErr;

    ej2_ctrl_seq_if #(.CTRL_W(4), .ADDR_W(3)) bus ();

    ej2_ctrl_seq #(.CTRL_W(4), .DEPTH(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_STEP_EN
    always_comb bus.step = stepDrive;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model: a started run is a list of words to show; each advance consumes one
    task automatic updateModel();
        bit prevBusy;
        int len;
        if (!rst_n) begin
            foreach (modelMem[i]) modelMem[i] = 4'b0000;
            runQ.delete();
            inFin    = 1'b0;
            modelIdx = 0;
            expWrErr = 1'b0;
            return;
        end
        prevBusy = (runQ.size() > 0);
        expWrErr = bus.prog_we && prevBusy;
        if (bus.prog_we && !prevBusy) modelMem[bus.prog_addr] = bus.prog_data;
        if (prevBusy) begin
            if (stepDrive) begin
                void'(runQ.pop_front());
                modelIdx++;
                if (runQ.size() == 0) inFin = 1'b1;
            end
        end else if (inFin) begin
            inFin = 1'b0;
        end else if (bus.start) begin
            len      = (int'(bus.seq_len) > 8) ? 8 : int'(bus.seq_len);
            modelIdx = 0;
            for (int i = 0; i < len; i++) runQ.push_back(modelMem[i]);
            if (len == 0) inFin = 1'b1;
        end
    endtask

    task automatic stepCycle();
        bit expBusy;
        @(posedge clk);
        updateModel();
        #1;
        expBusy = (runQ.size() > 0);
        checkOutput("control", 32'(bus.control), expBusy ? 32'(runQ[0]) : 32'd0);
        checkOutput("busy",    32'(bus.busy),    32'(expBusy));
        checkOutput("done",    32'(bus.done),    32'(inFin));
        checkOutput("wr_err",  32'(bus.wr_err),  32'(expWrErr));
        if (expBusy) checkOutput("seq_idx", 32'(bus.seq_idx), 32'(modelIdx));
    endtask

    task automatic applyStimulus(input bit we, input logic [2:0] addr, input logic [3:0] data,
                                 input logic [3:0] len, input bit go, input bit step,
                                 input bit rstn);
        bus.prog_we   = we;
        bus.prog_addr = addr;
        bus.prog_data = data;
        bus.seq_len   = len;
        bus.start     = go;
        stepDrive     = step;
        rst_n         = rstn;
        stepCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 1);
    endtask

    initial begin
        logic [3:0] prog [5];
        prog[0] = T0_EN;
        prog[1] = T1_EN;
        prog[2] = T2_EN;
        prog[3] = T3_EN;
        prog[4] = T0_EN | T1_EN;

        bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
        bus.seq_len = 0; bus.start = 0; stepDrive = 1; rst_n = 0;
        #1;
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 0);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 0);

        // Basic five-word run, with a dropped write at idx 2
        for (int i = 0; i < 5; i++) applyStimulus(1, 3'(i), prog[i], 4'd0, 0, 1, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd5, 1, 1, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 1);
        applyStimulus(1, 3'd2, 4'b1111, 4'd0, 0, 1, 1);
        idleCycles(6);
        applyStimulus(0, 3'd0, 4'd0, 4'd5, 1, 1, 1);
        idleCycles(7);

        // Zero-length run
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 1, 1, 1);
        idleCycles(3);

        // Clamped length
        applyStimulus(0, 3'd0, 4'd0, 4'd12, 1, 1, 1);
        idleCycles(10);

        // Reset mid-run, then replay of cleared memory
        applyStimulus(0, 3'd0, 4'd0, 4'd5, 1, 1, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 0);
        idleCycles(2);
        applyStimulus(0, 3'd0, 4'd0, 4'd3, 1, 1, 1);
        idleCycles(5);

        // Write and start in the same idle cycle, then start held through FIN
        applyStimulus(1, 3'd0, 4'b1010, 4'd2, 1, 1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 3'd0, 4'd0, 4'd1, 1, 1, 1);
        idleCycles(3);

`ifdef SEQ_STEP_EN
        applyStimulus(1, 3'd0, T0_EN, 4'd0, 0, 1, 1);
        applyStimulus(1, 3'd1, T1_EN, 4'd0, 0, 1, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd2, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 0, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 1);
        applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 1, 1);
        idleCycles(3);
`endif

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 2) == 0,
`ifdef SEQ_STEP_EN
                          $urandom_range(0, 1) == 1,
`else
                          1'b1,
`endif
                          $urandom_range(0, 59) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
